// File: rtl/filter_ctrl_scheduler.sv
// Frame-synchronous filter configuration scheduler: BPM intake with clamp and
// running average, button-stepped mode FSM, start-of-frame commit, stale timeout.
//
// state  | meaning
// S_OFF  | filter disabled, mode threshold
// S_THR  | filter enabled, threshold mode
// S_ADD  | filter enabled, additive mode
module filter_ctrl_scheduler #(
  parameter int MIN_BPM        = 40,
  parameter int MAX_BPM        = 200,
  parameter int AVG_LEN        = 4,
  parameter int TIMEOUT_FRAMES = 120,
  localparam int BW = $clog2(MAX_BPM + 1),
  localparam int AW = $clog2(AVG_LEN),
  localparam int SW = BW + AW,
  localparam int CW = $clog2(TIMEOUT_FRAMES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] bpm_in,
  input  logic          bpm_valid,
  output logic          bpm_ready,
  input  logic          mode_btn,
  input  logic          sof,
  output logic          filter_enable,
  output logic          filter_mode,
  output logic [BW-1:0] BPM_estimate,
  output logic          cfg_update,
  output logic          stale
);

  localparam logic [BW-1:0] MIN_V     = BW'(MIN_BPM);
  localparam logic [BW-1:0] MAX_V     = BW'(MAX_BPM);
  localparam logic [SW-1:0] SUM_RESET = SW'(MIN_BPM * AVG_LEN);
  localparam logic [CW-1:0] TO_V      = CW'(TIMEOUT_FRAMES);

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_THR = 2'd1,
    S_ADD = 2'd2
  } mode_state_t;

  mode_state_t   state_q, state_d;
  logic          pend_en, pend_mode;

  logic [BW-1:0] hist_mem [AVG_LEN];
  logic [AW-1:0] wr_ptr;
  logic [SW-1:0] sum;
  logic [BW-1:0] clamped;
  logic [BW-1:0] oldest;
  logic [BW-1:0] avg;
  logic [CW-1:0] frame_cnt;
  logic          accept;

  logic          commit_en;
  logic          commit_mode;
  logic [BW-1:0] commit_est;

  assign accept = bpm_valid && bpm_ready;
  assign oldest = hist_mem[wr_ptr];
  assign avg    = sum[SW-1:AW];

  always_comb begin
    clamped = bpm_in;
    if (bpm_in < MIN_V)
      clamped = MIN_V;
    else if (bpm_in > MAX_V)
      clamped = MAX_V;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bpm_ready <= 1'b0;
    else
      bpm_ready <= 1'b1;
  end

  // Circular history; the running sum swaps the oldest entry for the new one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < AVG_LEN; i++)
        hist_mem[i] <= MIN_V;
      wr_ptr <= '0;
      sum    <= SUM_RESET;
    end else if (accept) begin
      hist_mem[wr_ptr] <= clamped;
      wr_ptr           <= wr_ptr + AW'(1);
      sum              <= sum + SW'(clamped) - SW'(oldest);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      stale     <= 1'b0;
    end else if (accept) begin
      frame_cnt <= '0;
      stale     <= 1'b0;
    end else if (sof && frame_cnt != TO_V) begin
      frame_cnt <= frame_cnt + CW'(1);
      if (frame_cnt == TO_V - CW'(1))
        stale <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= S_OFF;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pend_en   = 1'b0;
    pend_mode = 1'b0;
    case (state_q)
      S_OFF: begin
        if (mode_btn) state_d = S_THR;
      end
      S_THR: begin
        pend_en = 1'b1;
        if (mode_btn) state_d = S_ADD;
      end
      S_ADD: begin
        pend_en   = 1'b1;
        pend_mode = 1'b1;
        if (mode_btn) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  // Commit uses pre-edge pending/stale/avg, so a same-edge sample or press lands next frame.
  assign commit_en   = pend_en & ~stale;
  assign commit_mode = pend_mode;
  assign commit_est  = stale ? MIN_V : avg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filter_enable <= 1'b0;
      filter_mode   <= 1'b0;
      BPM_estimate  <= MIN_V;
      cfg_update    <= 1'b0;
    end else if (sof) begin
      filter_enable <= commit_en;
      filter_mode   <= commit_mode;
      BPM_estimate  <= commit_est;
      cfg_update    <= (commit_en != filter_enable) || (commit_mode != filter_mode) ||
                       (commit_est != BPM_estimate);
    end else begin
      cfg_update <= 1'b0;
    end
  end

endmodule

// File: tb/tb_filter_ctrl_scheduler.sv
// Bench for filter_ctrl_scheduler: directed scenarios plus random traffic,
// every cycle compared against a queue-based frame-level reference model.
module tb_filter_ctrl_scheduler;

  localparam int MIN_BPM = 40;
  localparam int MAX_BPM = 200;
  localparam int AVG_LEN = 4;
  localparam int TO      = 3;
  localparam int BW      = $clog2(MAX_BPM + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [BW-1:0] bpm_in = '0;
  logic          bpm_valid = 1'b0;
  logic          bpm_ready;
  logic          mode_btn = 1'b0;
  logic          sof = 1'b0;
  logic          filter_enable;
  logic          filter_mode;
  logic [BW-1:0] BPM_estimate;
  logic          cfg_update;
  logic          stale;

  int errors = 0;
  int checks = 0;

  filter_ctrl_scheduler #(
    .MIN_BPM(MIN_BPM), .MAX_BPM(MAX_BPM), .AVG_LEN(AVG_LEN), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bpm_in(bpm_in), .bpm_valid(bpm_valid),
    .bpm_ready(bpm_ready), .mode_btn(mode_btn), .sof(sof),
    .filter_enable(filter_enable), .filter_mode(filter_mode),
    .BPM_estimate(BPM_estimate), .cfg_update(cfg_update), .stale(stale)
  );

  always #5 clk = ~clk;

  // Reference model: pending mode 0=off 1=threshold 2=additive; history as a queue.
  int m_ready, m_en, m_mode, m_est, m_cfg, m_stale, m_pend, m_frames;
  int hist[$];

  function automatic int m_avg();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s / AVG_LEN;
  endfunction

  task automatic model_reset();
    m_ready = 0; m_en = 0; m_mode = 0; m_est = MIN_BPM; m_cfg = 0;
    m_stale = 0; m_pend = 0; m_frames = 0;
    hist.delete();
    for (int i = 0; i < AVG_LEN; i++) hist.push_back(MIN_BPM);
  endtask

  task automatic model_edge(input bit v, input int bpm, input bit btn, input bit s);
    bit acc;
    int ne, nm, nest, c;
    acc = v && (m_ready != 0);
    if (s) begin
      ne   = (m_pend != 0 && m_stale == 0) ? 1 : 0;
      nm   = (m_pend == 2) ? 1 : 0;
      nest = (m_stale != 0) ? MIN_BPM : m_avg();
      m_cfg = (ne != m_en || nm != m_mode || nest != m_est) ? 1 : 0;
      m_en = ne; m_mode = nm; m_est = nest;
    end else begin
      m_cfg = 0;
    end
    if (btn) m_pend = (m_pend + 1) % 3;
    if (acc) begin
      c = (bpm < MIN_BPM) ? MIN_BPM : (bpm > MAX_BPM) ? MAX_BPM : bpm;
      hist.push_back(c);
      void'(hist.pop_front());
      m_frames = 0;
      m_stale = 0;
    end else if (s) begin
      if (m_frames < TO) m_frames++;
      if (m_frames == TO) m_stale = 1;
    end
    m_ready = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bpm_ready", 32'(bpm_ready), m_ready);
    chk("filter_enable", 32'(filter_enable), m_en);
    chk("filter_mode", 32'(filter_mode), m_mode);
    chk("BPM_estimate", 32'(BPM_estimate), m_est);
    chk("cfg_update", 32'(cfg_update), m_cfg);
    chk("stale", 32'(stale), m_stale);
  endtask

  task automatic cycle(input bit v, input int bpm, input bit btn, input bit s);
    bpm_valid = v; bpm_in = BW'(bpm); mode_btn = btn; sof = s;
    @(posedge clk);
    model_edge(v, bpm, btn, s);
    #1;
    check_all();
    bpm_valid = 1'b0; mode_btn = 1'b0; sof = 1'b0;
  endtask

  task automatic check_reset_consts(input string tag);
    chk({tag, "_ready"}, 32'(bpm_ready), 0);
    chk({tag, "_en"}, 32'(filter_enable), 0);
    chk({tag, "_mode"}, 32'(filter_mode), 0);
    chk({tag, "_est"}, 32'(BPM_estimate), MIN_BPM);
    chk({tag, "_cfg"}, 32'(cfg_update), 0);
    chk({tag, "_stale"}, 32'(stale), 0);
  endtask

  initial begin
    model_reset();
    // 1. reset
    repeat (3) begin
      @(posedge clk); #1;
      check_reset_consts("reset_hold");
      check_all();
    end
    @(negedge clk); reset = 1'b1;
    cycle(0, 0, 0, 0);
    chk("ready_after_release", 32'(bpm_ready), 1);
    cycle(0, 0, 0, 1);
    chk("idle_sof_no_cfg", 32'(cfg_update), 0);

    // 2. averaging
    cycle(1, 100, 0, 0); cycle(1, 120, 0, 0); cycle(1, 140, 0, 0); cycle(1, 160, 0, 0);
    cycle(0, 0, 0, 1);
    chk("avg_est_130", 32'(BPM_estimate), 130);
    chk("avg_cfg_pulse", 32'(cfg_update), 1);
    cycle(0, 0, 0, 0);
    chk("avg_cfg_one_cycle", 32'(cfg_update), 0);
    cycle(1, 100, 0, 0);
    cycle(0, 0, 0, 1);
    chk("avg_unchanged_est", 32'(BPM_estimate), 130);
    chk("avg_unchanged_no_cfg", 32'(cfg_update), 0);

    // 3. clamping
    repeat (4) cycle(1, 250, 0, 0);
    cycle(0, 0, 0, 1);
    chk("clamp_high", 32'(BPM_estimate), 200);
    repeat (4) cycle(1, 10, 0, 0);
    cycle(0, 0, 0, 1);
    chk("clamp_low", 32'(BPM_estimate), 40);

    // 4. mode cycling (a sample before each frame keeps the timeout away)
    cycle(1, 90, 0, 0); cycle(0, 0, 1, 0); cycle(0, 0, 0, 1);
    chk("mode_thr_en", 32'(filter_enable), 1); chk("mode_thr_mode", 32'(filter_mode), 0);
    cycle(1, 90, 0, 0); cycle(0, 0, 1, 0); cycle(0, 0, 0, 1);
    chk("mode_add_en", 32'(filter_enable), 1); chk("mode_add_mode", 32'(filter_mode), 1);
    cycle(1, 90, 0, 0); cycle(0, 0, 1, 0); cycle(0, 0, 0, 1);
    chk("mode_off_en", 32'(filter_enable), 0); chk("mode_off_mode", 32'(filter_mode), 0);
    cycle(0, 0, 1, 0); cycle(0, 0, 0, 0);
    chk("btn_nosof_en", 32'(filter_enable), 0); chk("btn_nosof_cfg", 32'(cfg_update), 0);
    cycle(1, 90, 0, 0);
    cycle(0, 0, 1, 1);
    chk("btn_sof_old_en", 32'(filter_enable), 1); chk("btn_sof_old_mode", 32'(filter_mode), 0);
    cycle(0, 0, 0, 1);
    chk("btn_sof_next_mode", 32'(filter_mode), 1);

    // 5. timeout, mode THRESH, avg 90
    cycle(1, 90, 0, 0); cycle(0, 0, 1, 0); cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("to_not_stale_2", 32'(stale), 0);
    cycle(0, 0, 0, 1);
    chk("to_stale_3", 32'(stale), 1);
    cycle(0, 0, 0, 1);
    chk("to_en_off", 32'(filter_enable), 0);
    chk("to_est_min", 32'(BPM_estimate), 40);
    chk("to_cfg", 32'(cfg_update), 1);
    cycle(1, 90, 0, 0);
    chk("to_cleared", 32'(stale), 0);
    cycle(0, 0, 0, 1);
    chk("to_recover_en", 32'(filter_enable), 1);
    chk("to_recover_est", 32'(BPM_estimate), 90);

    // 6. sample coincident with sof, then mid-frame reset
    cycle(1, 200, 0, 1);
    chk("simul_excluded", 32'(BPM_estimate), 90);
    cycle(0, 0, 0, 1);
    chk("simul_included", 32'(BPM_estimate), 117);
    cycle(0, 0, 1, 0); cycle(0, 0, 0, 1);
    chk("pre_reset_mode", 32'(filter_mode), 1);
    cycle(0, 0, 0, 0);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_consts("midframe_reset");
    @(posedge clk); #1;
    check_all();
    @(negedge clk); reset = 1'b1;
    cycle(0, 0, 0, 0);
    cycle(1, 150, 0, 0); cycle(0, 0, 1, 0); cycle(0, 0, 0, 1);
    chk("post_reset_pend_off_en", 32'(filter_enable), 1);
    chk("post_reset_pend_off_mode", 32'(filter_mode), 0);
    chk("post_reset_est", 32'(BPM_estimate), 67);

    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 255)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
